// File: rtl/vga_scan_gen.sv
// VGA raster timing generator with a centred, integer-scaled source window.
// Sync, blank and window flags are delayed PIPE pixel ticks to line up with framebuffer read data.
module vga_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 144,
  parameter int SCALE    = 3,
  parameter int PIPE     = 2
) (
  input  logic                             CLOCK_50,
  input  logic                             RESET_N,
  output logic                             VGA_CLK,
  output logic                             VGA_HS,
  output logic                             VGA_VS,
  output logic                             VGA_BLANK_N,
  output logic                             VGA_SYNC_N,
  output logic                             pix_tick,
  output logic                             fb_rd,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   fb_addr,
  output logic                             win_valid,
  output logic                             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(SRC_W * SRC_H);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW      = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int X_OFF   = (H_ACTIVE - SRC_W * SCALE) / 2;
  localparam int Y_OFF   = (V_ACTIVE - SRC_H * SCALE) / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] X_BEG    = HW'(X_OFF);
  localparam logic [HW-1:0] X_FIN    = HW'(X_OFF + SRC_W * SCALE);
  localparam logic [HW-1:0] X_LASTC  = HW'(X_OFF + SRC_W * SCALE - 1);
  localparam logic [VW-1:0] Y_BEG    = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_FIN    = VW'(Y_OFF + SRC_H * SCALE);
  localparam logic [VW-1:0] Y_LASTC  = VW'(Y_OFF + SRC_H * SCALE - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(SRC_W);
  localparam logic          HS_ACT   = 1'(HS_POL);
  localparam logic          VS_ACT   = 1'(VS_POL);

  if (SRC_W * SCALE > H_ACTIVE) begin : g_bad_w
    $error("vga_scan_gen: scaled source width exceeds H_ACTIVE");
  end
  if (SRC_H * SCALE > V_ACTIVE) begin : g_bad_h
    $error("vga_scan_gen: scaled source height exceeds V_ACTIVE");
  end

  logic [DW-1:0] div_r, div_next;
  logic          tick_next, pix_tick_r, frame_start_r, fb_rd_r;
  logic [HW-1:0] h_r, h_next;
  logic [VW-1:0] v_r, v_next;
  logic          hs_s, vs_s, act_s, win_s;
  logic [SW-1:0] sx_r, sy_r;
  logic [XW-1:0] src_x_r;
  logic [AW-1:0] row_base_r, fb_addr_r;
  logic [3:0]    pipe_r [0:PIPE];

  // Next divider/raster position; h/v already hold the pixel being emitted on the next tick
  always_comb begin
    div_next  = (div_r == DIV_LAST) ? '0 : div_r + 1'b1;
    tick_next = (div_next == DIV_LAST);
    h_next    = h_r;
    v_next    = v_r;
    if (pix_tick_r) begin
      if (h_r == H_LAST) begin
        h_next = '0;
        v_next = (v_r == V_LAST) ? '0 : v_r + 1'b1;
      end else begin
        h_next = h_r + 1'b1;
      end
    end else begin
      h_next = h_r;
    end
    hs_s  = (h_next >= HS_BEG) && (h_next < HS_END);
    vs_s  = (v_next >= VS_BEG) && (v_next < VS_END);
    act_s = (h_next < H_ACT) && (v_next < V_ACT);
    win_s = (h_next >= X_BEG) && (h_next < X_FIN) && (v_next >= Y_BEG) && (v_next < Y_FIN);
  end

  // Divider, raster counters and undelayed strobes
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_r         <= '0;
      h_r           <= '0;
      v_r           <= '0;
      pix_tick_r    <= 1'b0;
      frame_start_r <= 1'b0;
      fb_rd_r       <= 1'b0;
    end else begin
      div_r         <= div_next;
      h_r           <= h_next;
      v_r           <= v_next;
      pix_tick_r    <= tick_next;
      frame_start_r <= tick_next && (h_next == '0) && (v_next == '0);
      fb_rd_r       <= tick_next && win_s;
    end
  end

  // Replicating address walk: each source pixel/row is reused SCALE times, no multipliers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sx_r       <= '0;
      sy_r       <= '0;
      src_x_r    <= '0;
      row_base_r <= '0;
      fb_addr_r  <= '0;
    end else if (tick_next) begin
      if (win_s) begin
        fb_addr_r <= row_base_r + AW'(src_x_r);
        if (h_next == X_LASTC) begin
          sx_r    <= '0;
          src_x_r <= '0;
          if (v_next == Y_LASTC) begin
            sy_r       <= '0;
            row_base_r <= '0;
          end else if (sy_r == S_LAST) begin
            sy_r       <= '0;
            row_base_r <= row_base_r + ROW_STEP;
          end else begin
            sy_r <= sy_r + 1'b1;
          end
        end else if (sx_r == S_LAST) begin
          sx_r    <= '0;
          src_x_r <= src_x_r + 1'b1;
        end else begin
          sx_r <= sx_r + 1'b1;
        end
      end else if (h_next == '0) begin
        sx_r    <= '0;
        src_x_r <= '0;
        if (v_next == '0) begin
          sy_r       <= '0;
          row_base_r <= '0;
        end
      end
    end
  end

  // Flag delay line {hs, vs, active, window}, stepped once per pixel tick
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i <= PIPE; i++) pipe_r[i] <= 4'b0000;
    end else if (tick_next) begin
      pipe_r[0] <= {hs_s, vs_s, act_s, win_s};
      for (int i = 1; i <= PIPE; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  if (CLK_DIV == 1) begin : g_clk_pass
    assign VGA_CLK = ~CLOCK_50 & RESET_N;
  end else begin : g_clk_div
    logic vga_clk_r;
    // Pixel clock high during the upper half of the divider count
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) vga_clk_r <= 1'b0;
      else          vga_clk_r <= (div_next >= DW'(CLK_DIV / 2));
    end
    assign VGA_CLK = vga_clk_r;
  end

  assign VGA_HS      = pipe_r[PIPE][3] ~^ HS_ACT;
  assign VGA_VS      = pipe_r[PIPE][2] ~^ VS_ACT;
  assign VGA_BLANK_N = pipe_r[PIPE][1];
  assign win_valid   = pipe_r[PIPE][0];
  assign VGA_SYNC_N  = 1'b0;
  assign pix_tick    = pix_tick_r;
  assign fb_rd       = fb_rd_r;
  assign fb_addr     = fb_addr_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen on a shrunken raster (24x17 total, 16x12 active):
// dut runs CLK_DIV=2/SCALE=3/PIPE=2, dut2 runs CLK_DIV=1/SCALE=2/PIPE=0/HS_POL=1.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic vclk, hs, vs, blank_n, sync_n, tick, rd, wv, fs;
  logic [3:0] addr;
  logic vclk2, hs2, vs2, blank_n2, sync_n2, tick2, rd2, wv2, fs2;
  logic [3:0] addr2;

  int vecs = 0;
  int errs = 0;

  vga_scan_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
                 .HS_POL(0), .VS_POL(0), .CLK_DIV(2),
                 .SRC_W(4), .SRC_H(3), .SCALE(3), .PIPE(2)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .VGA_CLK(vclk), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .pix_tick(tick), .fb_rd(rd),
    .fb_addr(addr), .win_valid(wv), .frame_start(fs));

  vga_scan_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
                 .HS_POL(1), .VS_POL(0), .CLK_DIV(1),
                 .SRC_W(4), .SRC_H(3), .SCALE(2), .PIPE(0)) dut2 (
    .CLOCK_50(clk), .RESET_N(rst_n), .VGA_CLK(vclk2), .VGA_HS(hs2), .VGA_VS(vs2),
    .VGA_BLANK_N(blank_n2), .VGA_SYNC_N(sync_n2), .pix_tick(tick2), .fb_rd(rd2),
    .fb_addr(addr2), .win_valid(wv2), .frame_start(fs2));

  function automatic bit is_hs(int h);
    return (h >= 18) && (h < 21);
  endfunction
  function automatic bit is_vs(int v);
    return (v >= 13) && (v < 15);
  endfunction
  function automatic bit is_act(int h, int v);
    return (h < 16) && (v < 12);
  endfunction
  function automatic bit in_win(int h, int v, int xo, int yo, int ww, int wh);
    return (h >= xo) && (h < xo + ww) && (v >= yo) && (v < yo + wh);
  endfunction
  function automatic int win_addr(int h, int v, int xo, int yo, int sc);
    return ((v - yo) / sc) * 4 + (h - xo) / sc;
  endfunction

  task automatic test_reset(input string tag);
    if (hs !== 1'b1)      begin $display("FAIL %s hs got %b want 1", tag, hs); errs++; end
    if (vs !== 1'b1)      begin $display("FAIL %s vs got %b want 1", tag, vs); errs++; end
    if (blank_n !== 1'b0) begin $display("FAIL %s blank_n got %b want 0", tag, blank_n); errs++; end
    if (wv !== 1'b0)      begin $display("FAIL %s win_valid got %b want 0", tag, wv); errs++; end
    if (rd !== 1'b0)      begin $display("FAIL %s fb_rd got %b want 0", tag, rd); errs++; end
    if (tick !== 1'b0)    begin $display("FAIL %s pix_tick got %b want 0", tag, tick); errs++; end
    if (fs !== 1'b0)      begin $display("FAIL %s frame_start got %b want 0", tag, fs); errs++; end
    if (addr !== 4'd0)    begin $display("FAIL %s fb_addr got %0d want 0", tag, addr); errs++; end
    if (vclk !== 1'b0)    begin $display("FAIL %s vga_clk got %b want 0", tag, vclk); errs++; end
    if (sync_n !== 1'b0)  begin $display("FAIL %s sync_n got %b want 0", tag, sync_n); errs++; end
    if (hs2 !== 1'b0)     begin $display("FAIL %s hs2 got %b want 0", tag, hs2); errs++; end
    if (vclk2 !== 1'b0)   begin $display("FAIL %s vga_clk2 got %b want 0", tag, vclk2); errs++; end
    if (tick2 !== 1'b0)   begin $display("FAIL %s pix_tick2 got %b want 0", tag, tick2); errs++; end
    if (addr2 !== 4'd0)   begin $display("FAIL %s fb_addr2 got %0d want 0", tag, addr2); errs++; end
    vecs += 14;
  endtask

  // Cycle c counts posedges since reset release; both DUTs checked each cycle at the negedge.
  task automatic test_scan(input int ncyc, input string tag);
    int k, h, v, kd, hd, vd, k2, h2, v2;
    int rd_cnt, wv_cnt, rd2_cnt, first_h, first_v, last_h, last_v, last_a;
    bit t, e_act, e_win, e_hs, e_vs, e_rd, w2;
    logic [3:0] e_addr, e_addr2;
    e_addr = 4'd0; e_addr2 = 4'd0;
    rd_cnt = 0; wv_cnt = 0; rd2_cnt = 0;
    first_h = -1; first_v = -1; last_h = -1; last_v = -1; last_a = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      t = (c % 2) == 1;
      k = (c - 1) / 2;
      h = k % 24;
      v = (k / 24) % 17;
      kd = k - 2;
      hd = (kd < 0) ? 0 : kd % 24;
      vd = (kd < 0) ? 0 : (kd / 24) % 17;
      e_hs  = (kd >= 0) && is_hs(hd);
      e_vs  = (kd >= 0) && is_vs(vd);
      e_act = (kd >= 0) && is_act(hd, vd);
      e_win = (kd >= 0) && in_win(hd, vd, 2, 1, 12, 9);
      e_rd  = t && in_win(h, v, 2, 1, 12, 9);
      if (e_rd) e_addr = 4'(win_addr(h, v, 2, 1, 3));
      if (tick !== t)           begin $display("FAIL %s pix_tick c=%0d got %b want %b", tag, c, tick, t); errs++; end
      if (vclk !== t)           begin $display("FAIL %s vga_clk c=%0d got %b want %b", tag, c, vclk, t); errs++; end
      if (fs !== (t && h == 0 && v == 0)) begin $display("FAIL %s frame_start c=%0d got %b", tag, c, fs); errs++; end
      if (hs !== !e_hs)         begin $display("FAIL %s hs c=%0d got %b want %b", tag, c, hs, !e_hs); errs++; end
      if (vs !== !e_vs)         begin $display("FAIL %s vs c=%0d got %b want %b", tag, c, vs, !e_vs); errs++; end
      if (blank_n !== e_act)    begin $display("FAIL %s blank_n c=%0d got %b want %b", tag, c, blank_n, e_act); errs++; end
      if (wv !== e_win)         begin $display("FAIL %s win_valid c=%0d got %b want %b", tag, c, wv, e_win); errs++; end
      if (rd !== e_rd)          begin $display("FAIL %s fb_rd c=%0d got %b want %b", tag, c, rd, e_rd); errs++; end
      if (addr !== e_addr)      begin $display("FAIL %s fb_addr c=%0d got %0d want %0d", tag, c, addr, e_addr); errs++; end
      vecs += 9;
      if (c <= 816 && rd === 1'b1) begin
        rd_cnt++;
        if (first_h < 0) begin first_h = h; first_v = v; end
        last_h = h; last_v = v; last_a = int'(addr);
      end
      if (c <= 816 && t && wv === 1'b1) wv_cnt++;
      // dut2: one tick per clock, no pipeline delay, active-high hsync
      k2 = c - 1;
      h2 = k2 % 24;
      v2 = (k2 / 24) % 17;
      w2 = in_win(h2, v2, 4, 3, 8, 6);
      if (w2) e_addr2 = 4'(win_addr(h2, v2, 4, 3, 2));
      if (tick2 !== 1'b1)             begin $display("FAIL %s pix_tick2 c=%0d got %b want 1", tag, c, tick2); errs++; end
      if (vclk2 !== 1'b1)             begin $display("FAIL %s vga_clk2 c=%0d got %b want 1", tag, c, vclk2); errs++; end
      if (fs2 !== (h2 == 0 && v2 == 0)) begin $display("FAIL %s frame_start2 c=%0d got %b", tag, c, fs2); errs++; end
      if (hs2 !== is_hs(h2))          begin $display("FAIL %s hs2 c=%0d got %b want %b", tag, c, hs2, is_hs(h2)); errs++; end
      if (vs2 !== !is_vs(v2))         begin $display("FAIL %s vs2 c=%0d got %b want %b", tag, c, vs2, !is_vs(v2)); errs++; end
      if (blank_n2 !== is_act(h2, v2)) begin $display("FAIL %s blank_n2 c=%0d got %b", tag, c, blank_n2); errs++; end
      if (wv2 !== w2)                 begin $display("FAIL %s win_valid2 c=%0d got %b want %b", tag, c, wv2, w2); errs++; end
      if (rd2 !== w2)                 begin $display("FAIL %s fb_rd2 c=%0d got %b want %b", tag, c, rd2, w2); errs++; end
      if (addr2 !== e_addr2)          begin $display("FAIL %s fb_addr2 c=%0d got %0d want %0d", tag, c, addr2, e_addr2); errs++; end
      vecs += 9;
      if (c <= 408 && rd2 === 1'b1) rd2_cnt++;
    end
    if (ncyc >= 816) begin
      if (rd_cnt !== 108)  begin $display("FAIL %s fb_rd_count got %0d want 108", tag, rd_cnt); errs++; end
      if (wv_cnt !== 108)  begin $display("FAIL %s win_valid_count got %0d want 108", tag, wv_cnt); errs++; end
      if (rd2_cnt !== 48)  begin $display("FAIL %s fb_rd2_count got %0d want 48", tag, rd2_cnt); errs++; end
      if (first_h !== 2 || first_v !== 1) begin $display("FAIL %s first_rd got h=%0d v=%0d want h=2 v=1", tag, first_h, first_v); errs++; end
      if (last_h !== 13 || last_v !== 9 || last_a !== 11) begin $display("FAIL %s last_rd got h=%0d v=%0d a=%0d want 13/9/11", tag, last_h, last_v, last_a); errs++; end
      vecs += 5;
    end
  endtask

  task automatic test_frames();
    @(negedge clk);
    rst_n = 1'b1;
    test_scan(1632, "frames");
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_scan(261, "pre_reset");
    #1 rst_n = 1'b0;
    #1 test_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    test_scan(816, "post_reset");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset("reset");
    test_frames();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
